// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling default and parity-mode encoding.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  // Parity-mode encoding shared with the APB UART transmitter.
  localparam logic PARITY_ODD  = 1'b0;
  localparam logic PARITY_EVEN = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } rx_state_e;

  // Data-bit counts outside 5..8 fall back to 8.
  function automatic logic [3:0] eff_data_bits(input logic [3:0] db);
    return ((db >= 4'd5) && (db <= 4'd8)) ? db : 4'd8;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Divisor counter producing sample ticks plus a sample-within-bit counter.
module uart_baud_tick #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CD_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic [CD_W-1:0] cd,
  output logic            tick_c,
  output logic            mid_c,
  output logic            wrap_c
);

  localparam int unsigned SAMP_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);

  logic [CD_W-1:0]   div_cnt;
  logic [CD_W-1:0]   div_max;
  logic [SAMP_W-1:0] samp_cnt;

  // A divisor of 0 behaves like 1.
  assign div_max = (cd == '0) ? '0 : cd - CD_W'(1);
  assign tick_c  = en & (div_cnt == div_max);
  assign mid_c   = (samp_cnt == SAMP_MID);
  assign wrap_c  = (samp_cnt == SAMP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
    end else if (clr) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
    end else if (en) begin
      if (div_cnt == div_max) begin
        div_cnt  <= '0;
        samp_cnt <= wrap_c ? '0 : samp_cnt + SAMP_W'(1);
      end else begin
        div_cnt <= div_cnt + CD_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// 16x-oversampling UART receiver: deframes bytes, checks parity/stop bits and
// delivers them over valid/ready with sticky error flags.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int unsigned CD_W       = 16
) (
  input  logic            PCLK,
  input  logic            PRESET,
  input  logic [CD_W-1:0] cd_i,
  input  logic [3:0]      data_bits_i,
  input  logic            parity_en_i,
  input  logic            parity_even_i,
  input  logic            stop_bit_twice_i,
  input  logic            rxd_i,
  output logic [7:0]      data_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            parity_err_o,
  output logic            frame_err_o,
  output logic            overrun_o,
  input  logic            err_clr_i,
  output logic            busy_o
);

  logic            sync1, rx_s, rx_q;
  rx_state_e       state_q, state_d;
  logic [CD_W-1:0] cd_q;
  logic [3:0]      nbits_q;
  logic            par_en_q, par_even_q, stop2_q;
  logic [7:0]      shreg;
  logic [2:0]      idx;
  logic            par_acc, pend_par, pend_frm, done_q;
  logic            tick_c, mid_c, wrap_c;
  logic            mid_evt_c, wrap_evt_c, start_c, done_c, last_bit_c;

  // Two-flop synchronizer plus previous-sample flop for edge detection.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      sync1 <= rxd_i;
      rx_s  <= sync1;
      rx_q  <= rx_s;
    end
  end

  uart_baud_tick #(
    .OVERSAMPLE (OVERSAMPLE),
    .CD_W       (CD_W)
  ) u_baud_tick (
    .clk    (PCLK),
    .rst    (PRESET),
    .en     (busy_o),
    .clr    (start_c),
    .cd     (cd_q),
    .tick_c (tick_c),
    .mid_c  (mid_c),
    .wrap_c (wrap_c)
  );

  assign mid_evt_c  = tick_c & mid_c;
  assign wrap_evt_c = tick_c & wrap_c;
  assign last_bit_c = ({1'b0, idx} == (nbits_q - 4'd1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      IDLE: if (rx_q && !rx_s) begin
        state_d = START;
        start_c = 1'b1;
      end
      START: begin
        if (mid_evt_c && rx_s) state_d = IDLE;
        else if (wrap_evt_c)   state_d = DATA;
      end
      DATA: if (wrap_evt_c && last_bit_c) state_d = par_en_q ? PARITY : STOP1;
      PARITY: if (wrap_evt_c) state_d = STOP1;
      STOP1: begin
        if (stop2_q) begin
          if (wrap_evt_c) state_d = STOP2;
        end else if (mid_evt_c) begin
          state_d = IDLE;
          done_c  = 1'b1;
        end
      end
      STOP2: if (mid_evt_c) begin
        state_d = IDLE;
        done_c  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Configuration latch, shift register, running parity and pending error flags.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cd_q       <= '0;
      nbits_q    <= 4'd8;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
      stop2_q    <= 1'b0;
      shreg      <= '0;
      idx        <= '0;
      par_acc    <= 1'b0;
      pend_par   <= 1'b0;
      pend_frm   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= done_c;
      if (start_c) begin
        cd_q       <= cd_i;
        nbits_q    <= eff_data_bits(data_bits_i);
        par_en_q   <= parity_en_i;
        par_even_q <= parity_even_i;
        stop2_q    <= stop_bit_twice_i;
        shreg      <= '0;
        idx        <= '0;
        par_acc    <= 1'b0;
        pend_par   <= 1'b0;
        pend_frm   <= 1'b0;
      end else begin
        case (state_q)
          DATA: begin
            if (mid_evt_c) begin
              shreg[idx] <= rx_s;
              par_acc    <= par_acc ^ rx_s;
            end
            if (wrap_evt_c && !last_bit_c) idx <= idx + 3'd1;
          end
          PARITY: if (mid_evt_c)
            pend_par <= (par_even_q == PARITY_EVEN) ? (par_acc ^ rx_s) : ~(par_acc ^ rx_s);
          STOP1, STOP2: if (mid_evt_c && !rx_s) pend_frm <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Delivery, handshake and sticky flags; a new error beats a coincident clear.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      busy_o <= (state_d != IDLE);
      if (done_q && (!valid_o || ready_i)) begin
        data_o  <= shreg;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      overrun_o    <= (overrun_o & ~err_clr_i) | (done_q & valid_o & ~ready_i);
      parity_err_o <= (parity_err_o & ~err_clr_i) | (done_q & pend_par);
      frame_err_o  <= (frame_err_o & ~err_clr_i) | (done_q & pend_frm);
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: serial frames in, scoreboarded bytes out.
module tb_uart_rx_deframer;

  localparam int unsigned CD_W = 16;
  localparam int BIT_CYC = 64;

  logic            PCLK = 1'b0;
  logic            PRESET = 1'b1;
  logic [CD_W-1:0] cd_i = 16'd4;
  logic [3:0]      data_bits_i = 4'd8;
  logic            parity_en_i = 1'b1;
  logic            parity_even_i = 1'b1;
  logic            stop_bit_twice_i = 1'b1;
  logic            rxd_i = 1'b1;
  logic [7:0]      data_o;
  logic            valid_o;
  logic            ready_i = 1'b0;
  logic            parity_err_o, frame_err_o, overrun_o;
  logic            err_clr_i = 1'b0;
  logic            busy_o;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  rec_t exp_q[$];
  rec_t got_q[$];
  int checks = 0;
  int errors = 0;

  uart_rx_deframer dut (
    .PCLK             (PCLK),
    .PRESET           (PRESET),
    .cd_i             (cd_i),
    .data_bits_i      (data_bits_i),
    .parity_en_i      (parity_en_i),
    .parity_even_i    (parity_even_i),
    .stop_bit_twice_i (stop_bit_twice_i),
    .rxd_i            (rxd_i),
    .data_o           (data_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .parity_err_o     (parity_err_o),
    .frame_err_o      (frame_err_o),
    .overrun_o        (overrun_o),
    .err_clr_i        (err_clr_i),
    .busy_o           (busy_o)
  );

  always #5 PCLK = ~PCLK;

  // Record every accepted byte together with the flags visible at acceptance.
  always @(negedge PCLK) begin
    if (!PRESET && valid_o && ready_i)
      got_q.push_back('{d: data_o, pe: parity_err_o, fe: frame_err_o});
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  function automatic logic calc_par(input logic [7:0] d, input int nbits, input logic even);
    logic [7:0] m;
    m = 8'((1 << nbits) - 1);
    return even ? ^(d & m) : ~^(d & m);
  endfunction

  task automatic drive_bit(input logic b);
    rxd_i = b;
    repeat (BIT_CYC) @(negedge PCLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                            input logic pbit, input logic s1, input logic s2, input logic two);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(s1);
    if (two) drive_bit(s2);
    rxd_i = 1'b1;
  endtask

  task automatic wait_got(output rec_t r, output bit ok);
    ok = 1'b0;
    r  = '0;
    for (int i = 0; i < 2000; i++) begin
      if (got_q.size() > 0) begin
        r  = got_q.pop_front();
        ok = 1'b1;
        break;
      end
      @(negedge PCLK);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_got: no byte accepted within 2000 cycles");
    end
  endtask

  task automatic set_cfg(input logic [3:0] nb, input logic even, input logic two);
    cd_i = 16'd4;
    data_bits_i = nb;
    parity_en_i = 1'b1;
    parity_even_i = even;
    stop_bit_twice_i = two;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge PCLK);
    checks++;
    if ({data_o, valid_o, parity_err_o, frame_err_o, overrun_o, busy_o} !== 13'h0) begin
      errors++;
      $display("FAIL reset outputs: got data=%h v=%b pe=%b fe=%b ov=%b busy=%b, required all 0",
               data_o, valid_o, parity_err_o, frame_err_o, overrun_o, busy_o);
    end
    PRESET = 1'b0;
    repeat (3) @(negedge PCLK);
    checks++;
    if ({valid_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset idle: got v=%b busy=%b, required 0 0", valid_o, busy_o);
    end
  endtask

  task automatic test_clean();
    rec_t r, e;
    bit ok;
    set_cfg(4'd8, 1'b1, 1'b1);
    ready_i = 1'b1;
    exp_q.push_back('{d: 8'h6D, pe: 1'b0, fe: 1'b0});
    send_frame(8'h6D, 8, 1'b1, calc_par(8'h6D, 8, 1'b1), 1'b1, 1'b1, 1'b1);
    e = exp_q.pop_front();
    wait_got(r, ok);
    if (ok) begin
      checks++;
      if (r !== e) begin
        errors++;
        $display("FAIL clean byte: got d=%h pe=%b fe=%b, required d=%h pe=%b fe=%b",
                 r.d, r.pe, r.fe, e.d, e.pe, e.fe);
      end
    end
    @(negedge PCLK);
    checks++;
    if ({valid_o, overrun_o} !== 2'b00) begin
      errors++;
      $display("FAIL clean valid drop: got v=%b ov=%b, required 0 0", valid_o, overrun_o);
    end
    repeat (BIT_CYC) @(negedge PCLK);
  endtask

  task automatic test_back_to_back();
    rec_t r, e;
    bit ok;
    exp_q.push_back('{d: 8'h6D, pe: 1'b0, fe: 1'b0});
    exp_q.push_back('{d: 8'h79, pe: 1'b0, fe: 1'b0});
    send_frame(8'h6D, 8, 1'b1, calc_par(8'h6D, 8, 1'b1), 1'b1, 1'b1, 1'b1);
    send_frame(8'h79, 8, 1'b1, calc_par(8'h79, 8, 1'b1), 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      wait_got(r, ok);
      if (ok) begin
        checks++;
        if (r !== e) begin
          errors++;
          $display("FAIL b2b byte%0d: got d=%h pe=%b fe=%b, required d=%h pe=%b fe=%b",
                   k, r.d, r.pe, r.fe, e.d, e.pe, e.fe);
        end
      end
    end
    checks++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b overrun: got %b, required 0", overrun_o);
    end
    repeat (BIT_CYC) @(negedge PCLK);
  endtask

  task automatic test_errors();
    rec_t r, e;
    bit ok;
    exp_q.push_back('{d: 8'h79, pe: 1'b1, fe: 1'b0});
    send_frame(8'h79, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    e = exp_q.pop_front();
    wait_got(r, ok);
    if (ok) begin
      checks++;
      if (r !== e) begin
        errors++;
        $display("FAIL parity err byte: got d=%h pe=%b fe=%b, required d=%h pe=%b fe=%b",
                 r.d, r.pe, r.fe, e.d, e.pe, e.fe);
      end
    end
    exp_q.push_back('{d: 8'h48, pe: 1'b1, fe: 1'b1});
    send_frame(8'h48, 8, 1'b1, calc_par(8'h48, 8, 1'b1), 1'b1, 1'b0, 1'b1);
    e = exp_q.pop_front();
    wait_got(r, ok);
    if (ok) begin
      checks++;
      if (r !== e) begin
        errors++;
        $display("FAIL frame err byte: got d=%h pe=%b fe=%b, required d=%h pe=%b fe=%b",
                 r.d, r.pe, r.fe, e.d, e.pe, e.fe);
      end
    end
    repeat (BIT_CYC) @(negedge PCLK);
    checks++;
    if ({parity_err_o, frame_err_o, valid_o, busy_o} !== 4'b1100) begin
      errors++;
      $display("FAIL sticky hold: got pe=%b fe=%b v=%b busy=%b, required 1 1 0 0",
               parity_err_o, frame_err_o, valid_o, busy_o);
    end
    err_clr_i = 1'b1;
    @(negedge PCLK);
    err_clr_i = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({parity_err_o, frame_err_o} !== 2'b00) begin
      errors++;
      $display("FAIL err clear: got pe=%b fe=%b, required 0 0", parity_err_o, frame_err_o);
    end
  endtask

  task automatic test_overrun();
    rec_t r, e;
    bit ok;
    ready_i = 1'b0;
    send_frame(8'h45, 8, 1'b1, calc_par(8'h45, 8, 1'b1), 1'b1, 1'b1, 1'b1);
    send_frame(8'h4C, 8, 1'b1, calc_par(8'h4C, 8, 1'b1), 1'b1, 1'b1, 1'b1);
    checks++;
    if ({data_o, valid_o, overrun_o} !== {8'h45, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL overrun hold: got data=%h v=%b ov=%b, required 45 1 1",
               data_o, valid_o, overrun_o);
    end
    checks++;
    if ({parity_err_o, frame_err_o} !== 2'b00) begin
      errors++;
      $display("FAIL overrun flags: got pe=%b fe=%b, required 0 0", parity_err_o, frame_err_o);
    end
    exp_q.push_back('{d: 8'h45, pe: 1'b0, fe: 1'b0});
    @(posedge PCLK);
    #2 ready_i = 1'b1;
    e = exp_q.pop_front();
    wait_got(r, ok);
    if (ok) begin
      checks++;
      if (r !== e) begin
        errors++;
        $display("FAIL overrun drain: got d=%h pe=%b fe=%b, required d=%h pe=%b fe=%b",
                 r.d, r.pe, r.fe, e.d, e.pe, e.fe);
      end
    end
    repeat (4) @(negedge PCLK);
    checks++;
    if ({valid_o, 1'(got_q.size() != 0)} !== 2'b00) begin
      errors++;
      $display("FAIL overrun empty: got v=%b extra=%0d, required v=0 extra=0", valid_o, got_q.size());
    end
    err_clr_i = 1'b1;
    @(negedge PCLK);
    err_clr_i = 1'b0;
    @(negedge PCLK);
    checks++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL overrun clear: got %b, required 0", overrun_o);
    end
  endtask

  task automatic test_false_start_5bit();
    rec_t r, e;
    bit ok;
    rxd_i = 1'b0;
    repeat (20) @(negedge PCLK);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL glitch start: got busy=%b, required 1", busy_o);
    end
    rxd_i = 1'b1;
    repeat (100) @(negedge PCLK);
    checks++;
    if ({busy_o, valid_o, parity_err_o, frame_err_o, overrun_o, 1'(got_q.size() != 0)} !== 6'b0) begin
      errors++;
      $display("FAIL glitch reject: got busy=%b v=%b pe=%b fe=%b ov=%b got=%0d, required all 0",
               busy_o, valid_o, parity_err_o, frame_err_o, overrun_o, got_q.size());
    end
    set_cfg(4'd5, 1'b0, 1'b0);
    exp_q.push_back('{d: 8'h1F, pe: 1'b0, fe: 1'b0});
    send_frame(8'h1F, 5, 1'b1, calc_par(8'h1F, 5, 1'b0), 1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    wait_got(r, ok);
    if (ok) begin
      checks++;
      if (r !== e) begin
        errors++;
        $display("FAIL 5bit byte: got d=%h pe=%b fe=%b, required d=%h pe=%b fe=%b",
                 r.d, r.pe, r.fe, e.d, e.pe, e.fe);
      end
    end
    repeat (BIT_CYC) @(negedge PCLK);
  endtask

  task automatic test_reset_mid_frame();
    rec_t r, e;
    bit ok;
    set_cfg(4'd8, 1'b1, 1'b1);
    ready_i = 1'b0;
    send_frame(8'h33, 8, 1'b1, ~calc_par(8'h33, 8, 1'b1), 1'b1, 1'b1, 1'b1);
    checks++;
    if ({data_o, valid_o, parity_err_o} !== {8'h33, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL pre-reset state: got data=%h v=%b pe=%b, required 33 1 1",
               data_o, valid_o, parity_err_o);
    end
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rxd_i = 1'b0;
    repeat (20) @(negedge PCLK);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mid-frame busy: got %b, required 1", busy_o);
    end
    PRESET = 1'b1;
    #1;
    checks++;
    if ({data_o, valid_o, parity_err_o, frame_err_o, overrun_o, busy_o} !== 13'h0) begin
      errors++;
      $display("FAIL mid-frame reset: got data=%h v=%b pe=%b fe=%b ov=%b busy=%b, required all 0",
               data_o, valid_o, parity_err_o, frame_err_o, overrun_o, busy_o);
    end
    @(negedge PCLK);
    rxd_i = 1'b1;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    ready_i = 1'b1;
    repeat (BIT_CYC) @(negedge PCLK);
    exp_q.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0});
    send_frame(8'h5A, 8, 1'b1, calc_par(8'h5A, 8, 1'b1), 1'b1, 1'b1, 1'b1);
    e = exp_q.pop_front();
    wait_got(r, ok);
    if (ok) begin
      checks++;
      if (r !== e) begin
        errors++;
        $display("FAIL post-reset byte: got d=%h pe=%b fe=%b, required d=%h pe=%b fe=%b",
                 r.d, r.pe, r.fe, e.d, e.pe, e.fe);
      end
    end
    repeat (BIT_CYC) @(negedge PCLK);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_back_to_back();
    test_errors();
    test_overrun();
    test_false_start_5bit();
    test_reset_mid_frame();
    checks++;
    if ((exp_q.size() != 0) || (got_q.size() != 0)) begin
      errors++;
      $display("FAIL scoreboard drain: got exp=%0d got=%0d left, required 0 0",
               exp_q.size(), got_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Serial-line receiver that sits directly downstream of the APB UART's UART_TXD output.
- Recovers frames into bytes for loopback checking and for the board-side console bridge.
- Oversamples the line at 16x baud and checks start, parity and stop bits.
- Hands each byte to a consumer over a valid/ready handshake with sticky error flags.

Parameters:
- OVERSAMPLE, 16, sample ticks per bit; mid-bit sample taken at tick OVERSAMPLE/2-1.
- CD_W, 16, width of the clock-divisor input.

Ports:
- PCLK  in  1  system clock.
- PRESET  in  1  asynchronous active-high reset.
- cd_i  in  CD_W  PCLK cycles per sample tick; 0 is treated as 1.
- data_bits_i  in  4  data bits per frame, 5..8; values outside that range are treated as 8.
- parity_en_i  in  1  parity bit present.
- parity_even_i  in  1  1 = even parity, 0 = odd parity.
- stop_bit_twice_i  in  1  1 = two stop bits expected.
- rxd_i  in  1  asynchronous serial line, idle high.
- data_o  out  8  received byte, LSB first; bits above data_bits_i are zero.
- valid_o  out  1  data_o holds an unconsumed byte.
- ready_i  in  1  consumer accepts data_o when valid_o & ready_i.
- parity_err_o  out  1  sticky; set by a parity mismatch.
- frame_err_o  out  1  sticky; set when any stop bit samples 0.
- overrun_o  out  1  sticky; set when a byte completes while valid_o=1 and ready_i=0.
- err_clr_i  in  1  one-cycle pulse that clears all three sticky flags.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (PRESET=1, asynchronous) forces:
  - all outputs to 0;
  - FSM to IDLE;
  - both synchronizer flops and the previous-sample flop to 1.
- Synchronizer: rxd_i passes through a 2-flop synchronizer. Everything below uses the synchronized value rx_s, plus rx_q = rx_s delayed by one cycle.
- Tick generator:
  - A divisor counter runs only while busy_o=1.
  - It clears on entry to START.
  - It emits a one-cycle tick when count reaches max(cd_i,1)-1, then wraps to 0.
  - A sample counter (0..OVERSAMPLE-1) increments on each tick and wraps.
- Configuration latch: cd_i, data_bits_i, parity_en_i, parity_even_i and stop_bit_twice_i are latched on the IDLE->START transition. Changes to them mid-frame have no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: rx_q=1 & rx_s=0 (falling edge) -> START.
  - START: at the mid-sample, if rx_s=1 it is a false start -> IDLE with no flags touched. Otherwise, at sample wrap -> DATA with bit index 0.
  - DATA: at the mid-sample, shift rx_s into bit[index] and toggle the running parity. At wrap: if index = data_bits-1, go to PARITY when parity is enabled, else STOP1. Otherwise increment index.
  - PARITY: at the mid-sample, compare. For even parity the count of ones over data plus parity bit must be even; for odd parity it must be odd. A mismatch records a pending parity error. At wrap -> STOP1.
  - STOP1: at the mid-sample, rx_s=0 records a pending frame error. If two stop bits are configured, -> STOP2 at wrap. Otherwise complete the frame at this mid-sample and -> IDLE.
  - STOP2: at the mid-sample, same stop-bit check, then complete the frame and -> IDLE.
- Completion: frame completion is only at the mid-sample of the final stop bit. This lets a back-to-back start edge be detected half a bit later.
- Delivery: on the cycle after completion:
  - If valid_o=0, or valid_o=1 & ready_i=1 in the same cycle: load data_o, set valid_o=1, and apply the pending parity/frame flags.
  - If valid_o=1 & ready_i=0: drop the new byte, set overrun_o, and keep data_o unchanged. Pending flags are still applied.
- Handshake: valid_o falls on the cycle after valid_o & ready_i, unless a new byte is loaded in that same cycle. data_o is stable while valid_o=1 and not yet accepted.
- Sticky flags and clear: err_clr_i clears all sticky flags. If err_clr_i coincides with a new error being set, the set wins.
- Frame errors: a frame error still delivers the byte. The FSM rearms only on the next falling edge, so a held-low break line generates exactly one frame.
- Latency: valid_o rises 1 PCLK after the final stop-bit mid-sample. The start edge is detected 2-3 PCLK after rxd_i falls, because of the synchronizer.

Decomposition:
- Package uart_pkg holds:
  - rx_state_e enum (IDLE..STOP2);
  - OVERSAMPLE default;
  - the parity-mode encoding constants shared with APB_UART.
- One sub-module, uart_baud_tick: divisor counter plus sample counter, with enable/clear inputs and tick/mid/wrap outputs.

Test Plan:
- Clean frame:
  - Stimulus: cd_i=4, 8 data bits, even parity, two stop bits. Drive 0x6D (parity bit 1) at 64 PCLK per bit.
  - Required: data_o=0x6D, valid_o=1, all error flags 0; with ready_i=1, valid_o drops the next cycle.
- Back-to-back frames:
  - Stimulus: same configuration, 0x6D immediately followed by 0x79, ready_i held high.
  - Required: two valid pulses carrying 0x6D then 0x79, no errors.
- Parity and framing errors:
  - Stimulus: send 0x79 with parity bit 0 (even mode), then send 0x48 with second stop bit 0.
  - Required: first frame sets parity_err_o=1 with data_o=0x79. Second sets frame_err_o=1 with data_o=0x48. err_clr_i clears both.
- Overrun:
  - Stimulus: ready_i=0; receive 0x45 then 0x4C.
  - Required: data_o stays 0x45, overrun_o=1; asserting ready_i afterwards drains 0x45 and valid_o goes to 0.
- False start and 5-bit mode:
  - Stimulus: a 20-PCLK low glitch, then a 5-bit odd-parity, one-stop-bit frame carrying 0x1F.
  - Required: the glitch returns to IDLE with no valid_o and no flags. The frame gives data_o=0x1F with parity_err_o=0.
- Reset mid-frame:
  - Stimulus: assert PRESET during DATA bit 3.
  - Required: all outputs 0 immediately. The next full frame is received correctly.
